// File: rtl/dm_lsu_mem.sv
// dm_lsu_mem: byte/half/word/dword data memory with valid/ready request and registered response.
// Define DM_LSU_MEM_TRACE_EN to print each committed store as dm[index]=word.
module dm_lsu_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_W - LB);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-LB-1:0] idx;
  logic [LB-1:0] off;
  logic [6:0] w;
  logic [NB-1:0] be;
  logic [DATA_W-1:0] shf, msk, top, ld, wd;
  logic acc, err, sgn;
  assign idx = req_addr[ADDR_W-1:LB];
  assign off = req_addr[LB-1:0];
  assign req_ready = state == IDLE || rsp_ready;
  assign acc = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  // decode alignment, lane enables and the extended load value for the presented request
  always_comb begin
    err = (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
          (req_size == 2'd3 && (req_addr[2:0] != 3'd0 || DATA_W == 32));
    w = 7'd8 << req_size;
    be = NB'((32'd1 << (32'd1 << req_size)) - 32'd1) << off;
    shf = mem[idx] >> {off, 3'b000};
    msk = ~({DATA_W{1'b1}} << w);
    top = msk & ~(msk >> 1);
    sgn = !req_unsigned && |(shf & top);
    ld = err ? '0 : (shf & msk) | (sgn ? ~msk : '0);
    wd = req_wdata << {off, 3'b000};
  end
  // one response slot: a new accept always takes it, a drained slot with no accept goes idle
  always_comb state_nx = acc ? RESP : rsp_ready ? IDLE : state;
  // state and registered response, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        rsp_rdata <= req_we ? '0 : ld;
        rsp_err <= err;
      end
    end
  end
  // byte-lane store on the accepting edge; never while reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && acc && req_we && !err)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
`ifdef DM_LSU_MEM_TRACE_EN
  logic tr_v;
  logic [ADDR_W-LB-1:0] tr_idx;
  // remember the word written at the last commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_v <= 1'b0;
      tr_idx <= '0;
    end else begin
      tr_v <= rst_n && acc && req_we && !err;
      tr_idx <= idx;
    end
  end
  // print the post-write word the cycle after the commit
  always_ff @(posedge clk) begin
    if (tr_v) $display("dm[%X]=%X", tr_idx, mem[tr_idx]);
  end
`endif
endmodule

// File: doc/dm_lsu_mem.md
Name: dm_lsu_mem

Overview:
- Parametrised data memory with a valid/ready request channel and a registered response channel.
- Supports byte, halfword, word and (when DATA_W=64) doubleword loads and stores.
- Loads are sign- or zero-extended; misaligned accesses are flagged as errors.
- Sits between the pipeline MEM stage and local data RAM. It is the next generation of the word/byte data memory: variable width, full size set, single-outstanding handshake.

Parameters:
- ADDR_W, 12, byte-address width; array depth = 2^ADDR_W / (DATA_W/8) words.
- DATA_W, 32, data width; legal values 32 or 64.
- NB, DATA_W/8, byte lanes per word (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 dword
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal-size access

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
  - A pending response is discarded.
  - A store is committed only at an edge where rst_n=1 and the request is accepted.
- FSM states: IDLE, RESP.
  - req_ready = (state==IDLE) | rsp_ready (combinational).
  - Accept = req_valid & req_ready.
  - IDLE: accept -> RESP; otherwise stay.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready=1.
    - rsp_ready & accept -> stay RESP with the new response (full throughput, one access per cycle).
    - rsp_ready & !accept -> IDLE.
- Latency: response is registered and presented one cycle after the accepting edge.
- Word index = req_addr[ADDR_W-1:log2(NB)]; lane offset = req_addr[log2(NB)-1:0].
- Alignment error when any of:
  - size 1 with addr[0]=1;
  - size 2 with addr[1:0]!=0;
  - size 3 with addr[2:0]!=0;
  - size 3 when DATA_W=32 (illegal size).
- On error: no array write, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte-enable mask of 1/2/4/8 lanes starting at the lane offset.
  - Low 8/16/32/64 bits of req_wdata are placed in those lanes; other lanes are unchanged.
  - The write occurs on the accepting edge; rsp_rdata=0 and rsp_err=0 in the response.
- Load:
  - Array read at the accepting edge; selected lanes shifted to bit 0.
  - Bits above the access size are filled with the MSB of the access (signed) or 0 (unsigned).
  - Size equal to DATA_W is not extended.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Back-to-back accesses to the same word in consecutive cycles are required to work.
- Inputs are sampled only on accept; req_* may change freely otherwise.

Optional Feature:
- Macro DM_LSU_MEM_TRACE_EN.
- Defined: each committed store prints $display("dm[%X]=%X", word_index, post-write word) in the cycle after commit.
- Undefined: no simulation output; RTL otherwise identical.
- Errored stores never print.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x010, then word load @0x010 -> rsp_valid one cycle after accept, rdata=0xDEADBEEF, err=0.
- Byte store 0x80 @0x013, then signed byte load @0x013 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x010 -> 0x80ADBEEF.
- Half load @0x011 -> err=1, rdata=0, array unchanged. Word store @0x012 -> err=1, no write (confirmed by reload). DATA_W=32 with size 3 -> err=1.
- Hold rsp_ready=0 for 3 cycles after a load -> req_ready=0, rsp_rdata stable. Raise rsp_ready with req_valid=1 -> next request accepted in that cycle.
- DATA_W=64: dword store 0x0123456789ABCDEF @0x08, then signed half load @0x0E -> 0x0000000000000123; unsigned word load @0x0C -> 0x0000000001234567.
- Assert rst_n=0 while in RESP -> rsp_valid drops immediately; a store presented during reset is not committed; operation resumes normally after release.
